// File: rtl/fifo_tx_pkg.sv
// Shared types and constants for the FIFO-draining serial transmitter.
package fifo_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    POP    = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } tx_state_t;

  localparam logic TX_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module baud_tick_gen #(
  parameter int unsigned CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  // Free-running bit counter, restarted whenever the owner changes state.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/fifo_serial_tx.sv
// Drains one FIFO word per frame and shifts it out as start/data/parity/stop on tx.
module fifo_serial_tx
  import fifo_tx_pkg::*;
#(
  parameter int unsigned WIDTH        = 4,
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned PARITY_EN    = 1,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             empty,
  input  logic [WIDTH-1:0] poppedValue,
  output logic             pop,
  output logic             tx,
  output logic             busy,
  output logic             tx_done
);

  localparam int unsigned BW = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(WIDTH - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  tx_state_t        state;
  tx_state_t        state_next;
  logic             tick;
  logic             clear;
  logic [BW-1:0]    bit_cnt;
  logic [BW-1:0]    bit_cnt_next;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_next;
  logic             par;
  logic             par_next;
  logic             tx_next;

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .reset(reset),
    .clear(clear),
    .tick (tick)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state, datapath next values and Moore/Mealy outputs.
  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt;
    shift_next   = shift_reg;
    par_next     = par;
    pop          = 1'b0;
    tx_done      = 1'b0;
    case (state)
      IDLE: begin
        if (enable && !empty) state_next = POP;
      end
      POP: begin
        pop        = 1'b1;
        state_next = LOAD;
      end
      LOAD: begin
        shift_next = poppedValue;
        par_next   = ^poppedValue;
        state_next = START;
      end
      START: begin
        if (tick) state_next = DATA;
      end
      DATA: begin
        if (tick) begin
          shift_next = shift_reg >> 1;
          if (bit_cnt == LAST_DATA) begin
            state_next = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_cnt_next = bit_cnt + BW'(1);
          end
        end
      end
      PARITY: begin
        if (tick) state_next = STOP;
      end
      STOP: begin
        if (tick) begin
          if (bit_cnt == LAST_STOP) begin
            tx_done    = 1'b1;
            state_next = (enable && !empty) ? POP : IDLE;
          end else begin
            bit_cnt_next = bit_cnt + BW'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Bit and baud counters both restart on every state change.
    clear = (state_next != state);
    if (clear) bit_cnt_next = '0;

    // tx is registered from the upcoming state so the line never glitches.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      PARITY:  tx_next = par_next;
      default: tx_next = TX_IDLE_LEVEL;
    endcase
  end

  // Datapath and line registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
      par       <= 1'b0;
      tx        <= TX_IDLE_LEVEL;
    end else begin
      bit_cnt   <= bit_cnt_next;
      shift_reg <= shift_next;
      par       <= par_next;
      tx        <= tx_next;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Directed bench for fifo_serial_tx with a FIFO model and a frame scoreboard.
module tb_fifo_serial_tx;

  localparam int unsigned CPB   = 4;
  localparam int unsigned FRAME = 28;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic       empty = 1'b1;
  logic [3:0] poppedValue = '0;
  logic       pop;
  logic       tx;
  logic       busy;
  logic       tx_done;

  fifo_serial_tx #(
    .WIDTH(4),
    .CLKS_PER_BIT(4),
    .PARITY_EN(1),
    .STOP_BITS(1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .empty      (empty),
    .poppedValue(poppedValue),
    .pop        (pop),
    .tx         (tx),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  always #5 clk = ~clk;

  logic [3:0] fifo_q[$];
  logic [6:0] sb[$];
  int         pop_cycles[$];
  int         start_cycles[$];

  int n_assert = 0;
  int n_fail = 0;
  int cycle = 0;
  int pop_count = 0;
  int done_count = 0;
  int frames_done = 0;
  int frames_started = 0;
  int mon_cyc = 0;
  int last_pop_cycle = -100;
  bit in_frame = 1'b0;
  logic [6:0] cur_frame = '0;

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkn(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Word enters the FIFO; its expected frame (bit0 = start) enters the scoreboard.
  task automatic push_word(input logic [3:0] w);
    fifo_q.push_back(w);
    sb.push_back({1'b1, ^w, w, 1'b0});
    empty = 1'b0;
  endtask

  task automatic check_frame_sample();
    check1("tx_bit", tx, cur_frame[mon_cyc / CPB]);
    check1("tx_done", tx_done, mon_cyc == FRAME - 1);
    check1("busy_in_frame", busy, 1'b1);
    if (mon_cyc == FRAME - 1) begin
      in_frame = 1'b0;
      frames_done++;
    end
  endtask

  // One clock: FIFO model reacts to pop, then the line monitor checks tx.
  task automatic tick();
    logic p;
    logic r;
    p = pop;
    r = reset;
    @(posedge clk);
    #1;
    cycle++;
    if (p === 1'b1) begin
      check1("pop_nonempty", fifo_q.size() != 0, 1'b1);
      if (fifo_q.size() != 0) poppedValue = fifo_q.pop_front();
      pop_count++;
      last_pop_cycle = cycle - 1;
      pop_cycles.push_back(cycle - 1);
    end
    empty = (fifo_q.size() == 0);
    if (tx_done === 1'b1) done_count++;
    if (r === 1'b1) begin
      in_frame = 1'b0;
    end else if (in_frame) begin
      mon_cyc++;
      check_frame_sample();
    end else if (tx === 1'b0) begin
      in_frame = 1'b1;
      mon_cyc = 0;
      frames_started++;
      start_cycles.push_back(cycle);
      checkn("start_latency", cycle - last_pop_cycle, 2);
      check1("sb_nonempty", sb.size() != 0, 1'b1);
      if (sb.size() != 0) cur_frame = sb.pop_front();
      else cur_frame = '1;
      check_frame_sample();
    end else begin
      check1("idle_tx", tx, 1'b1);
      check1("idle_tx_done", tx_done, 1'b0);
    end
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n;
    n = 0;
    while (frames_done < target && n < budget) begin
      tick();
      n++;
    end
    check1("frame_done_timeout", frames_done >= target, 1'b1);
  endtask

  task automatic wait_starts(input int target, input int budget);
    int n;
    n = 0;
    while (frames_started < target && n < budget) begin
      tick();
      n++;
    end
    check1("frame_start_timeout", frames_started >= target, 1'b1);
  endtask

  task automatic wait_cyc(input int k, input int budget);
    int n;
    n = 0;
    while (!(in_frame && mon_cyc == k) && n < budget) begin
      tick();
      n++;
    end
    check1("frame_cycle_timeout", in_frame && mon_cyc == k, 1'b1);
  endtask

  initial begin
    // 1: reset held with a word waiting; nothing may happen.
    push_word(4'b1011);
    for (int i = 0; i < 3; i++) begin
      tick();
      check1("rst_tx", tx, 1'b1);
      check1("rst_pop", pop, 1'b0);
      check1("rst_busy", busy, 1'b0);
      check1("rst_tx_done", tx_done, 1'b0);
    end
    checkn("rst_no_pop", pop_count, 0);

    // 2: single frame of 4'b1011.
    reset = 1'b0;
    wait_frames(1, 60);
    tick();
    checkn("t2_pops", pop_count, 1);
    checkn("t2_done_pulses", done_count, 1);
    check1("t2_busy_after", busy, 1'b0);

    // 3: back-to-back frames 4'h3 then 4'h8.
    push_word(4'h3);
    push_word(4'h8);
    wait_frames(3, 100);
    tick();
    checkn("t3_pops", pop_count, 3);
    if (pop_cycles.size() >= 3) checkn("t3_pop_spacing", pop_cycles[2] - pop_cycles[1], 30);
    else checkn("t3_pop_records", pop_cycles.size(), 3);
    if (start_cycles.size() >= 3) checkn("t3_start_spacing", start_cycles[2] - start_cycles[1], 30);
    else checkn("t3_start_records", start_cycles.size(), 3);
    check1("t3_busy_after", busy, 1'b0);

    // 4: FIFO empty, enable high: the transmitter must stay idle.
    for (int i = 0; i < 100; i++) begin
      tick();
      check1("t4_tx", tx, 1'b1);
      check1("t4_busy", busy, 1'b0);
    end
    checkn("t4_pops", pop_count, 3);

    // 5: enable dropped mid-frame with more words queued.
    push_word(4'h5);
    push_word(4'hA);
    push_word(4'hF);
    wait_starts(4, 20);
    wait_cyc(10, 20);
    enable = 1'b0;
    wait_frames(4, 40);
    tick();
    check1("t5_busy_after", busy, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check1("t5_no_pop", pop, 1'b0);
      check1("t5_idle_busy", busy, 1'b0);
    end
    checkn("t5_pops", pop_count, 4);
    checkn("t5_fifo_left", fifo_q.size(), 2);

    // 6: reset mid-frame, then a fresh frame from the pending word.
    enable = 1'b1;
    wait_starts(5, 20);
    wait_cyc(12, 20);
    reset = 1'b1;
    tick();
    check1("t6_rst_tx", tx, 1'b1);
    check1("t6_rst_busy", busy, 1'b0);
    check1("t6_rst_pop", pop, 1'b0);
    reset = 1'b0;
    wait_frames(5, 60);
    tick();
    check1("t6_busy_after", busy, 1'b0);
    checkn("t6_pops", pop_count, 6);
    checkn("t6_fifo_left", fifo_q.size(), 0);
    checkn("t6_sb_left", sb.size(), 0);
    checkn("total_done_pulses", done_count, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
